dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the CPU data port and a debug/loader port.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port RAM between the CPU and debug ports,
// and owns the zero-fill sequencer that clears the RAM after reset or on command.
module dmem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16384,
  parameter int STARVE_LIMIT = 4,
  parameter int AUTO_CLEAR   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic              freeze,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_initialize,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic {S_RUN, S_CLEAR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] dbg_rd_q;
  logic              run;
  logic              cpu_win;
  logic              dbg_win;

  // Outputs are gated by rst_n so they take their reset values the moment reset asserts.
  assign run      = rst_n && (state == S_RUN);
  assign dbg_win  = run && dbg_req && ((starve_cnt == STV_MAX) || !cpu_req);
  assign cpu_win  = run && cpu_req && !dbg_win;
  assign cpu_gnt  = cpu_win;
  assign dbg_gnt  = dbg_win;
  assign clr_busy = rst_n && (state == S_CLEAR);

  assign cpu_rdata = cpu_win ? mem_out : cpu_rd_q;
  assign dbg_rdata = dbg_win ? mem_out : dbg_rd_q;

  always_comb begin
    mem_initialize = 1'b1;
    mem_load       = 1'b0;
    mem_address    = addr_q;
    mem_in         = in_q;
    if (!rst_n) begin
      mem_address = '0;
      mem_in      = '0;
    end else if (state == S_CLEAR) begin
      mem_initialize = 1'b0;
      mem_load       = 1'b1;
      mem_address    = ADDR_W'(clr_cnt);
      mem_in         = '0;
    end else begin
      mem_initialize = freeze;
      if (cpu_win) begin
        mem_load    = cpu_we;
        mem_address = cpu_addr;
        mem_in      = cpu_wdata;
      end else if (dbg_win) begin
        mem_load    = dbg_we;
        mem_address = dbg_addr;
        mem_in      = dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= (AUTO_CLEAR != 0) ? S_CLEAR : S_RUN;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      clr_done   <= 1'b0;
      addr_q     <= '0;
      in_q       <= '0;
      cpu_rd_q   <= '0;
      dbg_rd_q   <= '0;
    end else begin
      clr_done <= 1'b0;
      addr_q   <= mem_address;
      in_q     <= mem_in;
      if (cpu_win) cpu_rd_q <= mem_out;
      if (dbg_win) dbg_rd_q <= mem_out;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == CNT_LAST) begin
            state    <= S_RUN;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        default: begin
          // The grant of the clr_start cycle has already completed at this edge.
          if (clr_start) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            starve_cnt <= '0;
          end else if (dbg_req && !dbg_win) begin
            if (starve_cnt != STV_MAX) starve_cnt <= starve_cnt + STV_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM on the memory pins plus a reference model
// of memory contents, starvation count and held read data.
module tb_dmem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int DEPTH = 16384;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_start = 1'b0, freeze = 1'b0;
  logic clr_busy, clr_done;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic mem_initialize, mem_load;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in, mem_out;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM), .AUTO_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .freeze(freeze),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .mem_initialize(mem_initialize), .mem_load(mem_load),
    .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Behavioural data_memory: async read, write when load and not write-protected; bit 14 ignored.
  logic [DW-1:0] ram [0:DEPTH-1];
  assign mem_out = ram[mem_address[13:0]];
  always @(posedge clk) if (mem_load && !mem_initialize) ram[mem_address[13:0]] <= mem_in;

  int passed = 0;
  int total = 0;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int starve_m = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] cpu_hold = '0, dbg_hold = '0;
  bit cpu_hold_v = 0, dbg_hold_v = 0;

  function automatic void predict(output bit ec, output bit ed);
    ed = dbg_req && (starve_m >= LIM || !cpu_req);
    ec = cpu_req && !ed;
  endfunction

  // Apply the effects of the upcoming edge to the model.
  task automatic commit(input bit ec, input bit ed);
    logic [AW-1:0] a;
    logic we;
    logic [DW-1:0] wd;
    if (ec || ed) begin
      a  = ec ? cpu_addr : dbg_addr;
      we = ec ? cpu_we : dbg_we;
      wd = ec ? cpu_wdata : dbg_wdata;
      if (ec) begin cpu_hold = ref_mem[a[13:0]]; cpu_hold_v = 1; end
      else begin dbg_hold = ref_mem[a[13:0]]; dbg_hold_v = 1; end
      if (we && !freeze) ref_mem[a[13:0]] = wd;
      last_addr = a;
    end
    if (dbg_req && !ed) starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
    else starve_m = 0;
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_addr = AW'(DEPTH - 1);
    starve_m = 0;
  endtask

  task automatic test_reset();
    bit ec, ed;
    rst_n = 0; cpu_req = 1; dbg_req = 1; cpu_we = 1; dbg_we = 1;
    cpu_addr = 15'h0123; dbg_addr = 15'h0456; cpu_wdata = 16'hFFFF; dbg_wdata = 16'hAAAA;
    repeat (3) @(negedge clk);
    #1 total++;
    if ({cpu_gnt, dbg_gnt, clr_busy, clr_done, mem_load, mem_initialize} !== 6'b000001 ||
        mem_address !== '0 || mem_in !== '0)
      $display("FAIL reset_values got gnt=%b%b busy=%b done=%b load=%b init=%b addr=%h in=%h exp 000001/0/0",
               cpu_gnt, dbg_gnt, clr_busy, clr_done, mem_load, mem_initialize, mem_address, mem_in);
    else passed++;
    @(negedge clk) rst_n = 1; freeze = 1;
    for (int i = 0; i < 100; i++) begin
      #1 total++;
      if ({clr_busy, mem_load, mem_initialize, cpu_gnt, dbg_gnt} !== 5'b11000 ||
          mem_in !== '0 || mem_address !== AW'(i))
        $display("FAIL clear_seq_pre_abort i=%0d got busy/load/init/gnts=%b%b%b%b%b addr=%h in=%h exp 11000 addr=%h in=0",
                 i, clr_busy, mem_load, mem_initialize, cpu_gnt, dbg_gnt, mem_address, mem_in, AW'(i));
      else passed++;
      @(negedge clk);
    end
    rst_n = 0;
    #1 total++;
    if ({cpu_gnt, dbg_gnt, clr_busy, clr_done, mem_load, mem_initialize} !== 6'b000001 ||
        mem_address !== '0 || mem_in !== '0)
      $display("FAIL reset_abort got gnt=%b%b busy=%b done=%b load=%b init=%b addr=%h in=%h exp 000001/0/0",
               cpu_gnt, dbg_gnt, clr_busy, clr_done, mem_load, mem_initialize, mem_address, mem_in);
    else passed++;
    starve_m = 0; last_addr = '0; cpu_hold_v = 0; dbg_hold_v = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 total++;
      if ({clr_busy, mem_load, mem_initialize, cpu_gnt, dbg_gnt} !== 5'b11000 ||
          mem_in !== '0 || mem_address !== AW'(i))
        $display("FAIL clear_seq i=%0d got busy/load/init/gnts=%b%b%b%b%b addr=%h in=%h exp 11000 addr=%h in=0",
                 i, clr_busy, mem_load, mem_initialize, cpu_gnt, dbg_gnt, mem_address, mem_in, AW'(i));
      else passed++;
      @(negedge clk);
    end
    model_cleared();
    cpu_req = 1; cpu_we = 0; cpu_addr = '0; dbg_req = 0; freeze = 0;
    #1 predict(ec, ed);
    total++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || cpu_gnt !== 1'b1 || cpu_rdata !== ref_mem[0])
      $display("FAIL clear_done_read0 got done=%b busy=%b gnt=%b rdata=%h exp 1 0 1 %h",
               clr_done, clr_busy, cpu_gnt, cpu_rdata, ref_mem[0]);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_req = 0;
    #1 predict(ec, ed);
    total++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0)
      $display("FAIL clear_done_pulse got done=%b busy=%b exp 0 0", clr_done, clr_busy);
    else passed++;
    commit(ec, ed);
  endtask

  task automatic test_write_read();
    bit ec, ed;
    @(negedge clk) cpu_req = 1; cpu_we = 1; cpu_addr = 15'd5; cpu_wdata = 16'h1234; dbg_req = 0;
    #1 predict(ec, ed);
    total++;
    if (cpu_gnt !== 1'b1 || mem_load !== 1'b1 || mem_address !== 15'd5 || mem_in !== 16'h1234)
      $display("FAIL cpu_write got gnt=%b load=%b addr=%h in=%h exp 1 1 0005 1234", cpu_gnt, mem_load, mem_address, mem_in);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_we = 0;
    #1 predict(ec, ed);
    total++;
    if (cpu_gnt !== 1'b1 || cpu_rdata !== 16'h1234)
      $display("FAIL cpu_read got gnt=%b rdata=%h exp 1 1234", cpu_gnt, cpu_rdata);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_req = 0;
    #1 predict(ec, ed);
    total++;
    if (mem_load !== 1'b0 || mem_address !== 15'd5 || cpu_gnt !== 1'b0 || cpu_rdata !== 16'h1234)
      $display("FAIL idle_hold got load=%b addr=%h gnt=%b rdata=%h exp 0 0005 0 1234", mem_load, mem_address, cpu_gnt, cpu_rdata);
    else passed++;
    commit(ec, ed);
    @(negedge clk) dbg_req = 1; dbg_we = 1; dbg_addr = 15'h4010; dbg_wdata = 16'hA5A5;
    #1 predict(ec, ed);
    total++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_address !== 15'h4010 || mem_load !== 1'b1)
      $display("FAIL dbg_write got dgnt=%b cgnt=%b addr=%h load=%b exp 1 0 4010 1", dbg_gnt, cpu_gnt, mem_address, mem_load);
    else passed++;
    commit(ec, ed);
    @(negedge clk) dbg_we = 0; dbg_addr = 15'h0010;
    #1 predict(ec, ed);
    total++;
    if (dbg_gnt !== 1'b1 || dbg_rdata !== 16'hA5A5)
      $display("FAIL dbg_read_alias got gnt=%b rdata=%h exp 1 a5a5", dbg_gnt, dbg_rdata);
    else passed++;
    commit(ec, ed);
  endtask

  task automatic test_starvation();
    bit ec, ed, exp_d;
    @(negedge clk) cpu_req = 0; dbg_req = 0;
    #1 predict(ec, ed); commit(ec, ed);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk) cpu_req = 1; dbg_req = 1; cpu_we = 0; dbg_we = 0;
      cpu_addr = AW'($urandom_range(0, 31)); dbg_addr = AW'($urandom_range(0, 31));
      #1 predict(ec, ed);
      exp_d = (k % 5 == 4);
      total++;
      if (dbg_gnt !== exp_d || cpu_gnt !== !exp_d)
        $display("FAIL starve_pattern k=%0d got cgnt=%b dgnt=%b exp %b %b", k, cpu_gnt, dbg_gnt, !exp_d, exp_d);
      else passed++;
      commit(ec, ed);
    end
    @(negedge clk) cpu_req = 0; dbg_req = 0;
    #1 predict(ec, ed); commit(ec, ed);
  endtask

  task automatic test_freeze();
    bit ec, ed;
    @(negedge clk) cpu_req = 1; cpu_we = 1; cpu_addr = 15'd7; cpu_wdata = 16'h0003; freeze = 0;
    #1 predict(ec, ed); commit(ec, ed);
    @(negedge clk) cpu_wdata = 16'hBEEF; freeze = 1;
    #1 predict(ec, ed);
    total++;
    if (cpu_gnt !== 1'b1 || mem_initialize !== 1'b1)
      $display("FAIL freeze_write got gnt=%b init=%b exp 1 1", cpu_gnt, mem_initialize);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_we = 0;
    #1 predict(ec, ed);
    total++;
    if (cpu_gnt !== 1'b1 || cpu_rdata !== 16'h0003)
      $display("FAIL freeze_readback got gnt=%b rdata=%h exp 1 0003", cpu_gnt, cpu_rdata);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_req = 0; freeze = 0;
    #1 predict(ec, ed); commit(ec, ed);
  endtask

  task automatic test_random();
    bit ec, ed;
    logic [AW-1:0] ea;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cpu_req = 1'($urandom_range(0, 1)); dbg_req = ($urandom_range(0, 9) < 7);
      cpu_we = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      cpu_addr = {1'($urandom_range(0, 1)), 10'd0, 4'($urandom_range(0, 15))};
      dbg_addr = {1'($urandom_range(0, 1)), 10'd0, 4'($urandom_range(0, 15))};
      cpu_wdata = 16'($urandom); dbg_wdata = 16'($urandom);
      freeze = ($urandom_range(0, 7) == 0);
      #1 predict(ec, ed);
      ea = ec ? cpu_addr : (ed ? dbg_addr : last_addr);
      total++;
      if (cpu_gnt !== ec || dbg_gnt !== ed || mem_address !== ea || mem_initialize !== freeze ||
          mem_load !== ((ec && cpu_we) || (ed && dbg_we)))
        $display("FAIL rnd_arb n=%0d got gnt=%b%b addr=%h init=%b load=%b exp %b%b %h %b %b", n, cpu_gnt, dbg_gnt,
                 mem_address, mem_initialize, mem_load, ec, ed, ea, freeze, (ec && cpu_we) || (ed && dbg_we));
      else passed++;
      if (ec || cpu_hold_v) begin
        total++;
        if (cpu_rdata !== (ec ? ref_mem[cpu_addr[13:0]] : cpu_hold))
          $display("FAIL rnd_cpu_rdata n=%0d got %h exp %h", n, cpu_rdata, ec ? ref_mem[cpu_addr[13:0]] : cpu_hold);
        else passed++;
      end
      if (ed || dbg_hold_v) begin
        total++;
        if (dbg_rdata !== (ed ? ref_mem[dbg_addr[13:0]] : dbg_hold))
          $display("FAIL rnd_dbg_rdata n=%0d got %h exp %h", n, dbg_rdata, ed ? ref_mem[dbg_addr[13:0]] : dbg_hold);
        else passed++;
      end
      commit(ec, ed);
    end
    @(negedge clk) cpu_req = 0; dbg_req = 0; freeze = 0;
    #1 predict(ec, ed); commit(ec, ed);
  endtask

  task automatic test_clear_cmd();
    bit ec, ed;
    int bad;
    @(negedge clk) clr_start = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 15'd9; cpu_wdata = 16'h5555; dbg_req = 0;
    #1 predict(ec, ed);
    total++;
    if (cpu_gnt !== 1'b1 || clr_busy !== 1'b0 || mem_load !== 1'b1)
      $display("FAIL clr_cmd_same_cycle got gnt=%b busy=%b load=%b exp 1 0 1", cpu_gnt, clr_busy, mem_load);
    else passed++;
    commit(ec, ed);
    @(negedge clk) clr_start = 0; cpu_we = 0; dbg_req = 1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || clr_busy !== 1'b1 || mem_address !== AW'(i)) bad++;
      @(negedge clk);
    end
    total++;
    if (bad != 0) $display("FAIL clr_cmd_busy_window got %0d bad cycles exp 0", bad);
    else passed++;
    model_cleared();
    dbg_req = 0;
    #1 predict(ec, ed);
    total++;
    if (clr_done !== 1'b1 || cpu_gnt !== 1'b1 || cpu_rdata !== ref_mem[9])
      $display("FAIL clr_cmd_done_read got done=%b gnt=%b rdata=%h exp 1 1 %h", clr_done, cpu_gnt, cpu_rdata, ref_mem[9]);
    else passed++;
    commit(ec, ed);
    @(negedge clk) cpu_req = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_starvation();
    test_freeze();
    test_random();
    test_clear_cmd();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
